// File: rtl/sisc_ifetch_if.sv
// Instruction-memory read port for the SISC fetch stage.
// master drives the request, slave returns data with a one-cycle ack.
interface sisc_ifetch_if #(
    parameter int PC_W = 16
);
    logic            req;
    logic [PC_W-1:0] addr;
    logic            ack;
    logic [31:0]     rdata;

    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/sisc_ifetch.sv
// SISC instruction fetch / PC stage: PC, IR, field decode and next-PC.
// Optional fetch timeout enabled by defining SISC_IFETCH_TIMEOUT_EN.
module sisc_ifetch #(
    parameter int              PC_W    = 16,
    parameter logic [PC_W-1:0] RST_PC  = '0,
    parameter int              TMO_CYC = 15
) (
    input  logic            clk,
    input  logic            rst_f,
    input  logic            fetch_go,
    input  logic            pc_upd,
    input  logic [3:0]      stat,
    sisc_ifetch_if.master   imem,
    output logic [31:0]     instr,
    output logic [3:0]      opcode,
    output logic [3:0]      mm,
    output logic [3:0]      rd,
    output logic [3:0]      rs,
    output logic [3:0]      rt,
    output logic [15:0]     imm,
    output logic [PC_W-1:0] pc,
    output logic            ir_valid,
    output logic            busy,
    output logic            br_taken,
    output logic            fetch_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic [31:0] HLT = 32'hF000_0000;

    state_t          state_q, state_d;
    logic            ack_ok;
    logic            tmo_hit;
    logic            upd_ok;
    logic            cond;
    logic            taken;
    logic [PC_W-1:0] tgt;
    logic [PC_W-1:0] pc_next;
    logic [31:0]     abs32;
    logic [31:0]     sext32;

    assign opcode = instr[31:28];
    assign mm     = instr[27:24];
    assign rd     = instr[23:20];
    assign rs     = instr[19:16];
    assign rt     = instr[15:12];
    assign imm    = instr[15:0];

    assign busy      = (state_q == REQ) || (state_q == WAIT);
    assign imem.req  = busy;
    assign imem.addr = pc;
    assign upd_ok    = pc_upd && (state_q == IDLE) && ir_valid;

`ifdef SISC_IFETCH_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYC + 1);

    logic [CW-1:0] cnt_q;

    assign tmo_hit = (state_q == WAIT) && !imem.ack
                   && (cnt_q == CW'(TMO_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst_f) begin
            cnt_q     <= '0;
            fetch_err <= 1'b0;
        end else begin
            if ((state_q == WAIT) && !imem.ack)
                cnt_q <= cnt_q + 1'b1;
            else
                cnt_q <= '0;
            if (tmo_hit)
                fetch_err <= 1'b1;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ack_ok  = 1'b0;
        unique case (state_q)
            IDLE: if (fetch_go) state_d = REQ;
            REQ:  state_d = WAIT;
            WAIT: begin
                if (imem.ack) begin
                    ack_ok  = 1'b1;
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Branch targets: absolute zero-extends imm, relative sign-extends and wraps.
    always_comb begin
        abs32  = {16'h0000, imm};
        sext32 = {{16{imm[15]}}, imm};
        cond   = (mm == 4'h0) || ((stat & mm) != 4'h0);
        taken  = 1'b0;
        tgt    = pc + 1'b1;
        unique case (opcode)
            4'h4: begin taken = cond;  tgt = abs32[PC_W-1:0]; end
            4'h5: begin taken = cond;  tgt = pc + sext32[PC_W-1:0]; end
            4'h6: begin taken = !cond; tgt = abs32[PC_W-1:0]; end
            4'h7: begin taken = !cond; tgt = pc + sext32[PC_W-1:0]; end
            default: taken = 1'b0;
        endcase
        pc_next = taken ? tgt : pc + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q  <= IDLE;
            pc       <= RST_PC;
            instr    <= '0;
            ir_valid <= 1'b0;
            br_taken <= 1'b0;
        end else begin
            state_q <= state_d;
            if (upd_ok) begin
                pc       <= pc_next;
                br_taken <= taken;
            end
            if ((state_q == IDLE) && fetch_go)
                ir_valid <= 1'b0;
            if (ack_ok) begin
                instr    <= imem.rdata;
                ir_valid <= 1'b1;
            end else if (tmo_hit) begin
                instr    <= HLT;
                ir_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sisc_ifetch.sv
// Directed self-checking bench for sisc_ifetch.
// Timeout checks follow SISC_IFETCH_TIMEOUT_EN.
module tb_sisc_ifetch;
    logic        clk = 1'b0;
    logic        rst_f = 1'b1;
    logic        fetch_go = 1'b0;
    logic        pc_upd = 1'b0;
    logic [3:0]  stat = 4'h0;
    logic [31:0] instr;
    logic [3:0]  opcode, mm, rd, rs, rt;
    logic [15:0] imm;
    logic [15:0] pc;
    logic        ir_valid, busy, br_taken, fetch_err;

    int n_chk = 0;
    int n_fail = 0;

    sisc_ifetch_if #(.PC_W(16)) imem ();

    sisc_ifetch #(.PC_W(16), .RST_PC(16'h0000), .TMO_CYC(15)) dut (
        .clk(clk), .rst_f(rst_f), .fetch_go(fetch_go), .pc_upd(pc_upd),
        .stat(stat), .imem(imem), .instr(instr), .opcode(opcode),
        .mm(mm), .rd(rd), .rs(rs), .rt(rt), .imm(imm), .pc(pc),
        .ir_valid(ir_valid), .busy(busy), .br_taken(br_taken),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] d);
        fetch_go = 1'b1; tick(); fetch_go = 1'b0;
        tick();
        imem.ack = 1'b1; imem.rdata = d; tick();
        imem.ack = 1'b0;
    endtask

    task automatic upd(input logic [3:0] s);
        stat = s; pc_upd = 1'b1; tick(); pc_upd = 1'b0;
    endtask

    initial begin
        imem.ack = 1'b0;
        imem.rdata = 32'h0;
        tick(); tick();
        rst_f = 1'b0;
        chk("rst_pc", pc, 0);
        chk("rst_req", imem.req, 0);
        chk("rst_valid", ir_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_brt", br_taken, 0);
        chk("rst_err", fetch_err, 0);
        chk("rst_instr", instr, 0);

        upd(4'h0);
        chk("upd_noval_pc", pc, 0);

        // reset while WAIT, then late ack
        fetch_go = 1'b1; tick(); fetch_go = 1'b0;
        chk("req_req", imem.req, 1);
        chk("req_busy", busy, 1);
        tick(); tick();
        rst_f = 1'b1; tick(); rst_f = 1'b0;
        chk("midrst_pc", pc, 0);
        chk("midrst_req", imem.req, 0);
        chk("midrst_valid", ir_valid, 0);
        imem.ack = 1'b1; imem.rdata = 32'hDEAD_BEEF; tick(); imem.ack = 1'b0;
        chk("late_ack_instr", instr, 0);
        chk("late_ack_valid", ir_valid, 0);

        // sequential fetch at min latency
        fetch_go = 1'b1; tick(); fetch_go = 1'b0;
        chk("seq_req", imem.req, 1);
        chk("seq_addr", imem.addr, 16'h0000);
        tick();
        chk("seq_wait_valid", ir_valid, 0);
        imem.ack = 1'b1; imem.rdata = 32'h8123_4000; tick(); imem.ack = 1'b0;
        chk("seq_valid", ir_valid, 1);
        chk("seq_instr", instr, 32'h8123_4000);
        chk("seq_op", opcode, 4'h8);
        chk("seq_mm", mm, 4'h1);
        chk("seq_rd", rd, 4'h2);
        chk("seq_rs", rs, 4'h3);
        chk("seq_rt", rt, 4'h4);
        chk("seq_imm", imm, 16'h4000);
        chk("seq_idle_req", imem.req, 0);
        upd(4'h0);
        chk("seq_pc", pc, 16'h0001);
        chk("seq_brt", br_taken, 0);

        // BRA to 10, with an ack during REQ that must be ignored
        fetch_go = 1'b1; tick(); fetch_go = 1'b0;
        imem.ack = 1'b1; imem.rdata = 32'h1234_5678; tick(); imem.ack = 1'b0;
        chk("reqack_busy", busy, 1);
        tick();
        chk("reqack_still_busy", busy, 1);
        imem.ack = 1'b1; imem.rdata = 32'h4000_000A; tick(); imem.ack = 1'b0;
        chk("bra_instr", instr, 32'h4000_000A);
        upd(4'h0);
        chk("bra_pc", pc, 16'h000A);
        chk("bra_brt", br_taken, 1);

        // BRR backward taken: 10 - 4 = 6
        fetch(32'h5100_FFFC);
        upd(4'b0001);
        chk("brr_pc", pc, 16'h0006);
        chk("brr_brt", br_taken, 1);

        // pc_upd while busy ignored; BRR not taken at 6 -> 7
        fetch_go = 1'b1; tick(); fetch_go = 1'b0;
        pc_upd = 1'b1; tick(); pc_upd = 1'b0;
        chk("busy_upd_pc", pc, 16'h0006);
        imem.ack = 1'b1; imem.rdata = 32'h5100_FFFC; tick(); imem.ack = 1'b0;
        upd(4'b0000);
        chk("brr_nt_pc", pc, 16'h0007);
        chk("brr_nt_brt", br_taken, 0);

        // BNE from 0xFFFF
        fetch(32'h4000_FFFF);
        upd(4'h0);
        chk("to_ffff_pc", pc, 16'hFFFF);
        fetch(32'h6200_0040);
        upd(4'b0000);
        chk("bne_pc", pc, 16'h0040);
        chk("bne_brt", br_taken, 1);

        // NOOP wrap from 0xFFFF
        fetch(32'h4000_FFFF);
        upd(4'h0);
        fetch(32'h0000_0000);
        upd(4'h0);
        chk("wrap_pc", pc, 16'h0000);
        chk("wrap_brt", br_taken, 0);

        // BRA not taken (mm=8, stat misses) -> 1
        fetch(32'h4800_0030);
        upd(4'b0111);
        chk("bra_nt_pc", pc, 16'h0001);
        // BNR taken: 1 + 2 = 3
        fetch(32'h7100_0002);
        upd(4'b0000);
        chk("bnr_pc", pc, 16'h0003);
        chk("bnr_brt", br_taken, 1);

        // simultaneous fetch_go + pc_upd, then fetch_go while busy
        fetch(32'h4000_0020);
        fetch_go = 1'b1; pc_upd = 1'b1; stat = 4'h0; tick();
        pc_upd = 1'b0;
        chk("sim_pc", pc, 16'h0020);
        chk("sim_addr", imem.addr, 16'h0020);
        chk("sim_req", imem.req, 1);
        chk("sim_brt", br_taken, 1);
        chk("sim_valid", ir_valid, 0);
        tick(); fetch_go = 1'b0;
        imem.ack = 1'b1; imem.rdata = 32'h1000_0000; tick(); imem.ack = 1'b0;
        chk("once_instr", instr, 32'h1000_0000);
        chk("once_valid", ir_valid, 1);
        chk("once_busy", busy, 0);
        tick();
        chk("no_second_req", imem.req, 0);
        chk("no_second_busy", busy, 0);

        // timeout behaviour
        fetch_go = 1'b1; tick(); fetch_go = 1'b0;
        tick();
        for (int i = 0; i < 14; i++) tick();
        chk("tmo_busy_14", busy, 1);
        tick();
`ifdef SISC_IFETCH_TIMEOUT_EN
        chk("tmo_busy", busy, 0);
        chk("tmo_err", fetch_err, 1);
        chk("tmo_op", opcode, 4'hF);
        chk("tmo_valid", ir_valid, 1);
        tick();
        chk("tmo_sticky", fetch_err, 1);
        rst_f = 1'b1; tick(); rst_f = 1'b0;
        chk("tmo_rst_err", fetch_err, 0);
`else
        for (int i = 0; i < 10; i++) tick();
        chk("notmo_busy", busy, 1);
        chk("notmo_req", imem.req, 1);
        chk("notmo_err", fetch_err, 0);
        imem.ack = 1'b1; imem.rdata = 32'h2000_0000; tick(); imem.ack = 1'b0;
        chk("notmo_instr", instr, 32'h2000_0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
